// File: rtl/req_encoder_4to2_pkg.sv
// Shared widths, state encoding and helpers for the
// sequential 4-to-2 request encoder.
package req_encoder_4to2_pkg;

    localparam int IDX_W = 2;
    localparam int NREQ  = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // One-hot line for an encoded index
    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/req_encoder_4to2_sel.sv
// Combinational pick of one pending request: fixed
// priority (3 highest) or round-robin from ptr.
import req_encoder_4to2_pkg::*;

module prio_sel4 (
    input  logic [NREQ-1:0]  pend,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] j;

    // Later loop iterations win, so scan order puts the
    // preferred candidate last.
    always_comb begin
        idx = '0;
        j   = '0;
        any = |pend;
        if (rr) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                j = ptr + IDX_W'(i);
                if (pend[j]) idx = j;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder_4to2.sv
// Captures request pulses into pending bits and presents
// the encoded index with a VALID/ACK handshake.
import req_encoder_4to2_pkg::*;

module req_encoder_4to2 #(
    parameter bit RR = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic ACK,
    output logic A0,
    output logic A1,
    output logic VALID,
    output logic OVR
);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  pend_q, pend_d;
    logic [IDX_W-1:0] a_q, a_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             ovr_q, ovr_d;
    logic [NREQ-1:0]  set_v, clr_v;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;

    prio_sel4 u_sel (
        .pend (pend_q),
        .ptr  (ptr_q),
        .rr   (RR),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    // Next pending/overrun/handshake state; set beats clear
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        ptr_d   = ptr_q;
        set_v   = EN ? {D3, D2, D1, D0} : '0;
        clr_v   = '0;
        if (state_q == ST_PRESENT && ACK) clr_v = onehot(a_q);
        pend_d  = (pend_q & ~clr_v) | set_v;
        ovr_d   = |(set_v & pend_q & ~clr_v);
        unique case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d = ST_PRESENT;
                    a_d     = sel_idx;
                end
            end
            ST_PRESENT: begin
                if (ACK) begin
                    state_d = ST_IDLE;
                    if (RR) ptr_d = a_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            a_q     <= '0;
            ptr_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            ptr_q   <= ptr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign A0    = a_q[0];
    assign A1    = a_q[1];
    assign VALID = (state_q == ST_PRESENT);
    assign OVR   = ovr_q;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Directed bench: fixed-priority and round-robin
// instances driven by the same stimulus.
module tb_req_encoder_4to2;

    logic clk = 1'b0;
    logic rst, en, d0, d1, d2, d3, ack;
    logic a0_0, a1_0, v_0, o_0;
    logic a0_1, a1_1, v_1, o_1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    req_encoder_4to2 #(.RR(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .EN(en),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3),
        .ACK(ack), .A0(a0_0), .A1(a1_0),
        .VALID(v_0), .OVR(o_0)
    );

    req_encoder_4to2 #(.RR(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .EN(en),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3),
        .ACK(ack), .A0(a0_1), .A1(a1_1),
        .VALID(v_1), .OVR(o_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input logic [3:0] d);
        {d3, d2, d1, d0} = d;
    endtask

    // Compare {VALID, A1, A0, OVR} of one instance
    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] s0();
        return {v_0, a1_0, a0_0, o_0};
    endfunction

    function automatic logic [3:0] s1();
        return {v_1, a1_1, a0_1, o_1};
    endfunction

    task automatic do_reset();
        rst = 1'b1; ack = 1'b0; en = 1'b1; setd(4'b0000);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ack = 1'b0; setd(4'b1111);

        // 1: reset holds off requests, then they surface
        tick();
        chk("t1_rst_e1_d0", s0(), 4'b0000);
        tick();
        chk("t1_rst_e2_d0", s0(), 4'b0000);
        chk("t1_rst_e2_d1", s1(), 4'b0000);
        rst = 1'b0;
        tick();
        setd(4'b0000);
        chk("t1_post_e1", s0(), 4'b0000);
        tick();
        chk("t1_post_e2_d0", s0(), 4'b1110);
        chk("t1_post_e2_d1", s1(), 4'b1000);

        // 2: single request, hold, accept
        do_reset();
        setd(4'b0100);
        tick();
        setd(4'b0000);
        chk("t2_e1", s0(), 4'b0000);
        tick();
        chk("t2_present", s0(), 4'b1100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold", s0(), 4'b1100);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_ack", s0(), 4'b0100);
        tick();
        tick();
        chk("t2_idle", s0(), 4'b0100);

        // 3: fixed priority, D3 before D0, one bubble
        do_reset();
        setd(4'b1001);
        tick();
        setd(4'b0000);
        tick();
        chk("t3_first", s0(), 4'b1110);
        ack = 1'b1;
        tick();
        chk("t3_bubble", s0(), 4'b0110);
        tick();
        chk("t3_second", s0(), 4'b1000);
        tick();
        ack = 1'b0;
        chk("t3_done", s0(), 4'b0000);
        tick();
        chk("t3_empty", s0(), 4'b0000);

        // 4: EN gates capture
        do_reset();
        en = 1'b0;
        setd(4'b0010);
        tick();
        setd(4'b0000);
        tick();
        tick();
        chk("t4_gated", s0(), 4'b0000);
        en = 1'b1;
        setd(4'b0010);
        tick();
        setd(4'b0000);
        tick();
        chk("t4_present", s0(), 4'b1010);

        // 5: round-robin order and pointer wrap
        do_reset();
        setd(4'b1111);
        tick();
        setd(4'b0000);
        tick();
        chk("t5_rr_00", s1(), 4'b1000);
        chk("t5_fp_11", s0(), 4'b1110);
        ack = 1'b1;
        tick();
        chk("t5_rr_bub", s1(), 4'b0000);
        tick();
        chk("t5_rr_01", s1(), 4'b1010);
        chk("t5_fp_10", s0(), 4'b1100);
        tick();
        tick();
        chk("t5_rr_10", s1(), 4'b1100);
        chk("t5_fp_01", s0(), 4'b1010);
        tick();
        tick();
        chk("t5_rr_11", s1(), 4'b1110);
        chk("t5_fp_00", s0(), 4'b1000);
        tick();
        ack = 1'b0;
        chk("t5_rr_drain", s1(), 4'b0110);
        setd(4'b1111);
        tick();
        setd(4'b0000);
        tick();
        chk("t5_rr_wrap", s1(), 4'b1000);

        // 6: overrun pulse, and re-request on the ACK edge
        do_reset();
        setd(4'b0010);
        tick();
        tick();
        setd(4'b0000);
        chk("t6_ovr", s0(), 4'b1011);
        tick();
        chk("t6_ovr_clr", s0(), 4'b1010);
        ack = 1'b1;
        setd(4'b0010);
        tick();
        ack = 1'b0;
        setd(4'b0000);
        chk("t6_ack_set", s0(), 4'b0010);
        tick();
        chk("t6_again", s0(), 4'b1010);

        // Reset mid-handshake discards same-edge requests
        rst = 1'b1;
        setd(4'b1000);
        tick();
        rst = 1'b0;
        setd(4'b0000);
        chk("rst_mid", s0(), 4'b0000);
        tick();
        tick();
        chk("rst_mid_quiet", s0(), 4'b0000);
        chk("rst_mid_quiet1", s1(), 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
